// File: rtl/scope_frame_packer.sv
// Buffers one burst of signed 12-bit ADC samples, then streams it as a framed byte packet
// (sync, seq, length, sign-extended payload, checksum) over valid/ready.
module scope_frame_packer #(
   parameter int P_SEND_LEN = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [11:0] i_ad_data,
   input  logic        i_ad_data_vld,
   input  logic        i_ad_data_last,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   output logic        o_tx_last,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic [15:0] o_drop_cnt
);

   // state    | meaning
   // S_IDLE   | waiting for the first valid sample of a burst
   // S_CAPTURE| writing samples into the buffer, counting n
   // S_HDR    | emitting A5 5A seq n_hi n_lo
   // S_PAY    | emitting two bytes per buffered sample
   // S_CSUM   | emitting checksum, waiting for its transfer
   typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_HDR, S_PAY, S_CSUM} state_t;

   localparam int          AW  = (P_SEND_LEN > 1) ? $clog2(P_SEND_LEN) : 1;
   localparam logic [15:0] LEN = 16'(P_SEND_LEN);

   state_t          state, state_nxt;
   logic [11:0]     mem [P_SEND_LEN];
   logic [11:0]     rd_q;
   logic [AW-1:0]   rd_addr;
   logic [AW-1:0]   wr_addr;
   logic            wr_en;
   logic [15:0]     n;
   logic [15:0]     pidx;
   logic            phase;
   logic [2:0]      hidx;
   logic [7:0]      lo_hold;
   logic [7:0]      csum;
   logic [7:0]      seq;
   logic            vld_q;
   logic            ign_q;
   logic            in_tx;
   logic            slot_free;
   logic            xfer;
   logic            ld;
   logic [7:0]      ld_byte;
   logic            ld_last;
   logic            sum_en;
   logic            fr_done;

   assign in_tx     = (state == S_HDR) || (state == S_PAY) || (state == S_CSUM);
   assign slot_free = !o_tx_valid || i_tx_ready;
   assign xfer      = o_tx_valid && i_tx_ready;
   assign o_busy    = (state != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // The output register is loaded whenever it is empty or being emptied; state tracks the next byte to load.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_addr   = n[AW-1:0];
      ld        = 1'b0;
      ld_byte   = 8'h00;
      ld_last   = 1'b0;
      sum_en    = 1'b0;
      fr_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_ad_data_vld && !ign_q) begin
               wr_en     = 1'b1;
               wr_addr   = '0;
               state_nxt = (i_ad_data_last || LEN == 16'd1) ? S_HDR : S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (i_ad_data_vld) begin
               wr_en = 1'b1;
               if (i_ad_data_last || n == LEN - 16'd1) state_nxt = S_HDR;
            end
         end
         S_HDR: begin
            if (slot_free) begin
               ld = 1'b1;
               case (hidx)
                  3'd0:    ld_byte = 8'hA5;
                  3'd1:    ld_byte = 8'h5A;
                  3'd2:    begin ld_byte = seq;     sum_en = 1'b1; end
                  3'd3:    begin ld_byte = n[15:8]; sum_en = 1'b1; end
                  default: begin ld_byte = n[7:0];  sum_en = 1'b1; state_nxt = S_PAY; end
               endcase
            end
         end
         S_PAY: begin
            if (slot_free) begin
               ld      = 1'b1;
               sum_en  = 1'b1;
               ld_byte = phase ? lo_hold : {{4{rd_q[11]}}, rd_q[11:8]};
               if (phase && pidx == n - 16'd1) state_nxt = S_CSUM;
            end
         end
         S_CSUM: begin
            if (o_tx_valid && o_tx_last) begin
               if (i_tx_ready) begin
                  fr_done   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end else if (slot_free) begin
               ld      = 1'b1;
               ld_byte = csum;
               ld_last = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Buffer: read port runs only while transmitting, so it never overlaps capture writes.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= i_ad_data;
      if (state == S_HDR || state == S_PAY) rd_q <= mem[rd_addr];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tx_data  <= 8'h00;
         o_tx_valid <= 1'b0;
         o_tx_last  <= 1'b0;
         o_drop_cnt <= 16'h0000;
         n          <= 16'h0000;
         pidx       <= 16'h0000;
         phase      <= 1'b0;
         hidx       <= 3'd0;
         rd_addr    <= '0;
         lo_hold    <= 8'h00;
         csum       <= 8'h00;
         seq        <= 8'h00;
         vld_q      <= 1'b0;
         ign_q      <= 1'b0;
      end else begin
         vld_q <= i_ad_data_vld;
         // Any sample seen while transmitting poisons the rest of its burst.
         if (!i_ad_data_vld) ign_q <= 1'b0;
         else if (in_tx)     ign_q <= 1'b1;
         if (i_ad_data_vld && !vld_q && in_tx && o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
         if (wr_en) n <= (state == S_IDLE) ? 16'd1 : n + 16'd1;
         if (state == S_IDLE) begin
            hidx    <= 3'd0;
            pidx    <= 16'h0000;
            phase   <= 1'b0;
            rd_addr <= '0;
            csum    <= 8'h00;
         end
         if (ld) begin
            o_tx_data  <= ld_byte;
            o_tx_valid <= 1'b1;
            o_tx_last  <= ld_last;
            if (sum_en) csum <= csum + ld_byte;
            if (state == S_HDR) hidx <= hidx + 3'd1;
            if (state == S_PAY) begin
               if (!phase) begin
                  // Hold the low byte so the read port can prefetch the next sample.
                  lo_hold <= rd_q[7:0];
                  phase   <= 1'b1;
                  if (pidx != n - 16'd1) rd_addr <= rd_addr + AW'(1);
               end else begin
                  phase <= 1'b0;
                  pidx  <= pidx + 16'd1;
               end
            end
         end else if (xfer) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
         end
         if (fr_done) seq <= seq + 8'd1;
      end
   end

endmodule

// File: doc/scope_frame_packer.md
# scope_frame_packer

Downstream neighbour of the scope sample generator in the Ethernet path. It captures one burst of signed 12-bit ADC samples (valid/last framed, no backpressure) into an internal buffer. It then emits the burst as a byte stream with a header and checksum through a valid/ready handshake to the UDP transmit stage. While a frame is buffered or being sent, any new burst is dropped whole and counted.

## Interface
- P_SEND_LEN, 1000: maximum samples per frame (1..4095); buffer depth.
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ad_data  in  12  signed sample.
- i_ad_data_vld  in  1  sample valid, no backpressure.
- i_ad_data_last  in  1  final sample of burst; meaningful only with vld.
- o_tx_data  out  8  output byte.
- o_tx_valid  out  1  byte valid.
- o_tx_last  out  1  final byte of frame; qualified by valid.
- i_tx_ready  in  1  sink accepts byte when valid&ready.
- o_busy  out  1  high in any state other than IDLE.
- o_drop_cnt  out  16  dropped-burst count, saturates at 0xFFFF.

## Operation
- States and transitions:
  - IDLE to CAPTURE: on the first cycle with i_ad_data_vld=1; that sample is written as sample 0.
  - CAPTURE: writes each vld sample and counts samples in n.
  - CAPTURE to HDR: on vld&last, or when n reaches P_SEND_LEN.
  - HDR to PAY to CSUM to IDLE: each state advances as its bytes are accepted.
- Overlong burst: vld samples beyond P_SEND_LEN are ignored. The ignore lasts until vld has been low for at least one cycle, and those samples never start a new frame.
- Short burst: last before P_SEND_LEN gives n equal to the actual count.
- Frame byte order:
  - A5, 5A.
  - seq[7:0].
  - n[15:8], n[7:0].
  - For each sample d, in order: {{4{d[11]}}, d[11:8]}, then d[7:0].
  - csum.
  - Total length is 6+2n bytes.
- csum: sum mod 256 of every byte from seq through the last payload byte. Sync bytes are excluded.
- seq: starts at 0 and increments, wrapping at 256, after each frame's csum byte is accepted. Dropped bursts do not advance it.
- Drop rule:
  - A rising edge of i_ad_data_vld while in HDR, PAY or CSUM increments o_drop_cnt once.
  - The rest of that burst is ignored.
  - A burst still in progress when CSUM completes is also ignored until vld goes low.
- o_tx_last is 1 only on the csum byte.

## Timing
- Reset values:
  - o_tx_data=0, o_tx_valid=0, o_tx_last=0.
  - o_busy=0, o_drop_cnt=0.
  - seq=0, state IDLE.
- Handshake:
  - o_tx_data, o_tx_valid and o_tx_last are registered.
  - Once valid is high, data and last hold stable until valid&ready.
  - Valid never drops without a transfer.
- Latency: o_tx_valid rises with byte A5 at most 2 cycles after the cycle the closing sample is captured.
- Bubble-free: with i_tx_ready held at 1, o_tx_valid stays high for 6+2n consecutive cycles. Buffer read latency must be hidden by prefetch.
- After the csum transfer:
  - o_tx_valid is 0 the next cycle.
  - The state is IDLE.
  - A vld sample on the cycle after the csum transfer may start CAPTURE, unless the ignore rule applies.
- Reset mid-operation (asynchronous):
  - All state is cleared immediately and the partial frame is discarded.
  - o_tx_valid drops without handshake.
  - seq returns to 0.
- Write and read of the buffer never overlap, because capture and transmit are exclusive states.

## Test plan
- Basic frame, P_SEND_LEN=4, ready=1, samples 001, 7FF, 800, FFF with last on the 4th:
  - bytes A5 5A 00 00 04 00 01 07 FF F8 00 FF FF 01.
  - valid high 14 consecutive cycles.
  - last only on 01.
- Backpressure: same stimulus, i_tx_ready toggling 1,0,0,1 repeating:
  - identical byte sequence.
  - data/last stable on every valid&!ready cycle.
  - no byte lost or duplicated.
- Short frame, P_SEND_LEN=4: samples 010, 020, 030 with last on the 3rd:
  - header n=00 03.
  - 12 bytes total.
  - csum = (00+00+03+00+10+00+20+00+30) mod 256 = 0x63.
- Overlong and drop, P_SEND_LEN=4:
  - 6 vld samples, no last: n=4, samples 5 and 6 absent.
  - A second burst whose vld rises while ready=0 in PAY: o_drop_cnt=1, and the next transmitted frame carries seq=01.
- Reset mid-PAY: deassert i_rst_n after 7 bytes sent:
  - all outputs 0 immediately.
  - next burst sends seq=00 with a correct full frame.
- Seq wrap: send 257 frames; the 257th has seq=00 and o_drop_cnt stays 0.
